// File: rtl/alu.sv
// rtl/alu.sv - 32-bit ALU with a registered result stage
//
// Purpose:
//   Combinational datapath covering add/sub, and/or, logical and arithmetic
//   right shift, and signed/unsigned set-less-than. The result and its zero
//   flag are registered, so they appear one clock after the operands are
//   sampled. There is no handshake and no enable: a new op is taken every cycle.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   synchronous active-low reset (C=0, zero=1)
//   A      in  32   operand A; shift source for shift ops
//   B      in  32   operand B; B[4:0] is the shift amount for shift ops
//   ALUOp  in   3   operation select
//   C      out 32   registered result
//   zero   out  1   registered flag, high when C is all zeros

module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUOp,
  output logic [31:0] C,
  output logic        zero
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_SRL  = 3'b100,
    OP_SRA  = 3'b101,
    OP_SLT  = 3'b110,
    OP_SLTU = 3'b111
  } alu_op_e;

  logic [4:0]  shamt;
  logic [31:0] result_next;

  // Only the low five bits of B matter for shifts; upper bits are ignored.
  assign shamt = B[4:0];

  always_comb begin
    result_next = 32'h0;
    case (alu_op_e'(ALUOp))
      OP_ADD:  result_next = A + B;
      OP_SUB:  result_next = A - B;
      OP_AND:  result_next = A & B;
      OP_OR:   result_next = A | B;
      OP_SRL:  result_next = A >> shamt;
      // Cast to signed so >>> replicates A[31] into the vacated bits.
      OP_SRA:  result_next = $unsigned($signed(A) >>> shamt);
      OP_SLT:  result_next = {31'b0, ($signed(A) < $signed(B))};
      OP_SLTU: result_next = {31'b0, (A < B)};
      default: result_next = 32'h0;
    endcase
  end

  // zero is derived from the same next-state value as C so the two can never
  // disagree, and reset forces the pair to a consistent (0, 1) state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      C    <= 32'h0;
      zero <= 1'b1;
    end else begin
      C    <= result_next;
      zero <= (result_next == 32'h0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for alu

module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUOp;
  logic [31:0] C;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .ALUOp (ALUOp),
    .C     (C),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one operation, clock it in, then check C and zero just after the edge.
  task automatic step(input string tag, input logic rn, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] op,
                      input logic [31:0] exp_c, input logic exp_z);
    rst_n = rn;
    A     = a;
    B     = b;
    ALUOp = op;
    @(posedge clk);
    #1;
    chk({tag, ".C"}, C, exp_c);
    chk({tag, ".zero"}, {31'b0, zero}, {31'b0, exp_z});
  endtask

  initial begin
    rst_n = 1'b0;
    A     = 32'h0;
    B     = 32'h0;
    ALUOp = 3'b000;
    #2;

    // Reset held for two edges with a live ADD on the inputs.
    step("rst1", 1'b0, 32'h1234, 32'h1, 3'b000, 32'h0, 1'b1);
    step("rst2", 1'b0, 32'h1234, 32'h1, 3'b000, 32'h0, 1'b1);
    step("rel",  1'b1, 32'h1234, 32'h1, 3'b000, 32'h1235, 1'b0);

    // Arithmetic wrap
    step("add_wrap", 1'b1, 32'hFFFFFFFF, 32'h1, 3'b000, 32'h0, 1'b1);
    step("sub_wrap", 1'b1, 32'h0, 32'h1, 3'b001, 32'hFFFFFFFF, 1'b0);

    // Logic
    step("and", 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b010, 32'h00F000F0, 1'b0);
    step("or",  1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b011, 32'hFFF0FFF0, 1'b0);

    // Shifts, including ignored upper B bits and zero / 31 amounts
    step("sra4",    1'b1, 32'hFFFF0000, 32'h4,  3'b101, 32'hFFFFF000, 1'b0);
    step("srl4",    1'b1, 32'hFFFF0000, 32'h4,  3'b100, 32'h0FFFF000, 1'b0);
    step("sra_hiB", 1'b1, 32'hFFFF0000, 32'h24, 3'b101, 32'hFFFFF000, 1'b0);
    step("srl_hiB", 1'b1, 32'hFFFF0000, 32'h24, 3'b100, 32'h0FFFF000, 1'b0);
    step("sra0",    1'b1, 32'hFFFF0000, 32'h0,  3'b101, 32'hFFFF0000, 1'b0);
    step("srl0",    1'b1, 32'hFFFF0000, 32'h0,  3'b100, 32'hFFFF0000, 1'b0);
    step("sra31n",  1'b1, 32'h80000000, 32'h1F, 3'b101, 32'hFFFFFFFF, 1'b0);
    step("srl31n",  1'b1, 32'h80000000, 32'h1F, 3'b100, 32'h00000001, 1'b0);
    step("sra31p",  1'b1, 32'h7FFFFFFF, 32'h1F, 3'b101, 32'h0, 1'b1);
    step("srl_mid", 1'b1, 32'h80000010, 32'h3,  3'b100, 32'h10000002, 1'b0);

    // Compares
    step("slt_neg",  1'b1, 32'hFFFFFFFF, 32'h1, 3'b110, 32'h1, 1'b0);
    step("sltu_big", 1'b1, 32'hFFFFFFFF, 32'h1, 3'b111, 32'h0, 1'b1);
    step("slt_eq",   1'b1, 32'h5, 32'h5, 3'b110, 32'h0, 1'b1);
    step("sltu_eq",  1'b1, 32'h5, 32'h5, 3'b111, 32'h0, 1'b1);
    step("sltu_lt",  1'b1, 32'h4, 32'h5, 3'b111, 32'h1, 1'b0);
    step("slt_pos",  1'b1, 32'h1, 32'hFFFFFFFF, 3'b110, 32'h0, 1'b1);

    // Back-to-back ops with a reset dropped into the middle
    step("b2b_add",  1'b1, 32'h80000010, 32'h3, 3'b000, 32'h80000013, 1'b0);
    step("b2b_sub",  1'b1, 32'h80000010, 32'h3, 3'b001, 32'h8000000D, 1'b0);
    step("b2b_and",  1'b1, 32'h80000010, 32'h3, 3'b010, 32'h0, 1'b1);
    step("b2b_rst",  1'b0, 32'h80000010, 32'h3, 3'b011, 32'h0, 1'b1);
    step("b2b_or",   1'b1, 32'h80000010, 32'h3, 3'b011, 32'h80000013, 1'b0);
    step("b2b_sra",  1'b1, 32'h80000010, 32'h3, 3'b101, 32'hF0000002, 1'b0);
    step("b2b_slt",  1'b1, 32'h80000010, 32'h3, 3'b110, 32'h1, 1'b0);
    step("b2b_sltu", 1'b1, 32'h80000010, 32'h3, 3'b111, 32'h0, 1'b1);
    step("b2b_add2", 1'b1, 32'h7FFFFFFF, 32'h1, 3'b000, 32'h80000000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
